// File: rtl/delay_ram_ctrl.sv
// Circular delay-line controller for a 16-bit asynchronous SRAM: relative offsets become
// absolute addresses behind a write pointer, with programmable wait states and a zero-fill after reset.
module delay_ram_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 12,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 2,
    parameter int CLEAR_ON_RESET  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       rd,
    input  logic                       wr,
    input  logic [ADDR_WIDTH-1:0]      offset,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       read_finish,
    output logic                       write_finish,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0]      sram_dq_in,
    output logic [DATA_WIDTH-1:0]      sram_dq_out,
    output logic                       sram_dq_oe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n
);

    localparam logic [3:0] INIT_SETUP = 4'd0;
    localparam logic [3:0] INIT_PULSE = 4'd1;
    localparam logic [3:0] INIT_HOLD  = 4'd2;
    localparam logic [3:0] IDLE       = 4'd3;
    localparam logic [3:0] RD_ACCESS  = 4'd4;
    localparam logic [3:0] RD_DONE    = 4'd5;
    localparam logic [3:0] WR_SETUP   = 4'd6;
    localparam logic [3:0] WR_PULSE   = 4'd7;
    localparam logic [3:0] WR_DONE    = 4'd8;

    localparam logic [3:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT_SETUP : IDLE;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [3:0]                 state_reg, state_next;
    logic [SRAM_ADDR_WIDTH-1:0] wp_reg;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [SRAM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]      dq_out_reg, dq_out_next;
    logic [DATA_WIDTH-1:0]      data_out_reg, data_out_next;
    logic                       ce_n_reg, oe_n_reg, we_n_reg, dq_oe_reg;
    logic [SRAM_ADDR_WIDTH-1:0] offset_ext;
    logic [SRAM_ADDR_WIDTH-1:0] req_addr;

    // Only the low address bits matter because the subtraction wraps modulo the buffer depth.
    generate
        if (ADDR_WIDTH >= SRAM_ADDR_WIDTH) begin : g_off_trunc
            assign offset_ext = offset[SRAM_ADDR_WIDTH-1:0];
            if (ADDR_WIDTH > SRAM_ADDR_WIDTH) begin : g_hi
                logic unused_offset_hi;
                assign unused_offset_hi = ^offset[ADDR_WIDTH-1:SRAM_ADDR_WIDTH];
            end
        end else begin : g_off_ext
            assign offset_ext = {{(SRAM_ADDR_WIDTH-ADDR_WIDTH){1'b0}}, offset};
        end
    endgenerate

    assign req_addr = wp_reg - offset_ext;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        dq_out_next   = dq_out_reg;
        data_out_next = data_out_reg;
        case (state_reg)
            INIT_SETUP: begin
                state_next = INIT_PULSE;
                cnt_next   = '0;
            end
            INIT_PULSE: begin
                if (cnt_reg == CNT_LAST) state_next = INIT_HOLD;
                else                     cnt_next   = cnt_reg + 1'b1;
            end
            INIT_HOLD: begin
                if (addr_reg == '1) begin
                    state_next = IDLE;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = INIT_SETUP;
                end
            end
            IDLE: begin
                if (rd) begin
                    state_next = RD_ACCESS;
                    addr_next  = req_addr;
                    cnt_next   = '0;
                end else if (wr) begin
                    state_next  = WR_SETUP;
                    addr_next   = req_addr;
                    dq_out_next = data_in;
                end
            end
            RD_ACCESS: begin
                if (cnt_reg == CNT_LAST) begin
                    data_out_next = sram_dq_in;
                    state_next    = RD_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RD_DONE:  state_next = IDLE;
            WR_SETUP: begin
                state_next = WR_PULSE;
                cnt_next   = '0;
            end
            WR_PULSE: begin
                if (cnt_reg == CNT_LAST) state_next = WR_DONE;
                else                     cnt_next   = cnt_reg + 1'b1;
            end
            WR_DONE:  state_next = IDLE;
            default:  state_next = RESET_STATE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state and stay glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RESET_STATE;
            wp_reg       <= '0;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            dq_out_reg   <= '0;
            data_out_reg <= '0;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            dq_oe_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            dq_out_reg   <= dq_out_next;
            data_out_reg <= data_out_next;
            if (advance) wp_reg <= wp_reg + 1'b1;
            ce_n_reg     <= (state_next == IDLE);
            oe_n_reg     <= (state_next != RD_ACCESS);
            we_n_reg     <= !((state_next == WR_PULSE) || (state_next == INIT_PULSE));
            dq_oe_reg    <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                            (state_next == WR_DONE) || (state_next == INIT_SETUP) ||
                            (state_next == INIT_PULSE) || (state_next == INIT_HOLD);
        end
    end

    assign ready        = (state_reg == IDLE);
    assign read_finish  = (state_reg == RD_DONE);
    assign write_finish = (state_reg == WR_DONE);
    assign data_out     = data_out_reg;
    assign sram_addr    = addr_reg;
    assign sram_dq_out  = dq_out_reg;
    assign sram_dq_oe   = dq_oe_reg;
    assign sram_ce_n    = ce_n_reg;
    assign sram_oe_n    = oe_n_reg;
    assign sram_we_n    = we_n_reg;

endmodule

// File: tb/tb_delay_ram_ctrl.sv
// Randomized bench for delay_ram_ctrl: an SRAM model plus a cycle-numbered transaction
// model that predicts ready, finish pulses, strobes, address and read data on every cycle.
module tb_delay_ram_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int SAW   = 4;
    localparam int W     = 2;
    localparam int DEPTH = 1 << SAW;
    localparam int INIT_CYCLES = DEPTH * (W + 2);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           advance = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [AW-1:0]  offset = '0;
    logic [DW-1:0]  data_in = '0;
    logic [DW-1:0]  data_out;
    logic           read_finish, write_finish, ready;
    logic [SAW-1:0] sram_addr;
    logic [DW-1:0]  sram_dq_in, sram_dq_out;
    logic           sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    delay_ram_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SAW),
        .WAIT_CYCLES(W), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst), .advance(advance), .rd(rd), .wr(wr),
        .offset(offset), .data_in(data_in), .data_out(data_out),
        .read_finish(read_finish), .write_finish(write_finish), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model
    logic [DW-1:0] sram_mem [DEPTH];
    logic          prefill = 1'b0;
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 16'hFFFF;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: cycles are numbered by clock edges since reset release.
    int          m_cyc, m_ready_cycle, m_rf_cycle, m_wf_cycle;
    int          m_kind, m_T, m_end, m_addr, m_wp;
    bit          m_init;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_data_out, m_rd_data, m_wdata;
    bit          cmp_en = 1'b0;

    task automatic model_reset();
        m_cyc = 0; m_ready_cycle = INIT_CYCLES; m_rf_cycle = -1; m_wf_cycle = -1;
        m_kind = 0; m_T = -10; m_end = -10; m_addr = 0; m_wp = 0; m_init = 1'b1;
        m_data_out = '0; m_rd_data = '0; m_wdata = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge();
        int T;
        T = m_cyc;
        if (m_cyc >= m_ready_cycle) begin
            if (rd) begin
                m_kind = 1; m_T = T; m_addr = (m_wp - int'(offset)) & (DEPTH - 1);
                m_rd_data = m_mem[m_addr];
                m_rf_cycle = T + W + 1; m_end = T + W + 1; m_ready_cycle = T + W + 2;
            end else if (wr) begin
                m_kind = 2; m_T = T; m_addr = (m_wp - int'(offset)) & (DEPTH - 1);
                m_wdata = data_in; m_mem[m_addr] = data_in;
                m_wf_cycle = T + W + 2; m_end = T + W + 2; m_ready_cycle = T + W + 3;
            end
        end
        if (advance) m_wp = (m_wp + 1) & (DEPTH - 1);
        m_cyc++;
        if (m_cyc == m_rf_cycle) m_data_out = m_rd_data;
        if (m_cyc >= INIT_CYCLES) m_init = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit in_acc;
            check("ready", ready, m_cyc >= m_ready_cycle);
            check("read_finish", read_finish, m_cyc == m_rf_cycle);
            check("write_finish", write_finish, m_cyc == m_wf_cycle);
            check("data_out", data_out, m_data_out);
            if (m_init) begin
                check("init_ce_n", sram_ce_n, 1'b0);
                check("init_dq_oe", sram_dq_oe, 1'b1);
                check("init_oe_n", sram_oe_n, 1'b1);
            end else begin
                in_acc = (m_kind != 0) && (m_cyc > m_T) && (m_cyc <= m_end);
                check("ce_n", sram_ce_n, !in_acc);
                check("oe_n", sram_oe_n, !(m_kind == 1 && m_cyc > m_T && m_cyc <= m_T + W));
                check("we_n", sram_we_n, !(m_kind == 2 && m_cyc > m_T + 1 && m_cyc <= m_T + W + 1));
                check("dq_oe", sram_dq_oe, m_kind == 2 && in_acc);
                if (in_acc) check("sram_addr", sram_addr, m_addr);
                if (in_acc && m_kind == 2) check("sram_dq_out", sram_dq_out, m_wdata);
            end
        end
    end

    task automatic drive_cycle(input logic a, input logic r, input logic w,
                               input logic [AW-1:0] off, input logic [DW-1:0] din);
        advance = a; rd = r; wr = w; offset = off; data_in = din;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 100) begin
            drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
            k++;
        end
        check("wait_ready", ready, 1'b1);
    endtask

    // Releases reset at a falling edge with the SRAM pre-filled, then runs the clear with noise on rd/wr.
    task automatic reset_and_clear();
        prefill = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_finish", {read_finish, write_finish}, 2'b00);
        prefill = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 cmp_en = 1'b1;
        for (int i = 0; i < INIT_CYCLES - 1; i++)
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 16'($urandom));
        check("ready_before_64", ready, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
        check("ready_at_64", ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) check("clear_word", sram_mem[i], 16'h0000);
    endtask

    initial begin
        int rf_cnt;
        reset_and_clear();

        // Read back every word through the controller.
        for (int i = 0; i < DEPTH; i++) begin
            wait_ready();
            drive_cycle(1'b0, 1'b1, 1'b0, 12'(i), '0);
            idle_cycles(W + 1);
            check("readback_zero", data_out, 16'h0000);
        end

        // Write then read at wp=5.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        wait_ready();
        drive_cycle(1'b0, 1'b0, 1'b1, 12'd0, 16'h1234);
        check("wr_addr", sram_addr, 5);
        idle_cycles(2);
        check("wr_finish_early", write_finish, 1'b0);
        idle_cycles(1);
        check("wr_finish_T4", write_finish, 1'b1);
        check("sram_word5", sram_mem[5], 16'h1234);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        wait_ready();
        drive_cycle(1'b0, 1'b1, 1'b0, 12'd3, '0);
        check("rd_addr", sram_addr, 5);
        idle_cycles(2);
        check("rd_finish_T3", read_finish, 1'b1);
        check("rd_data", data_out, 16'h1234);

        // Pointer wrap 15 -> 0 and address wrap; wp is 8 here.
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        wait_ready();
        drive_cycle(1'b0, 1'b1, 1'b0, 12'd0, '0);
        check("wp15_addr", sram_addr, 15);
        drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        wait_ready();
        drive_cycle(1'b0, 1'b1, 1'b0, 12'd0, '0);
        check("wp_wrap_addr", sram_addr, 0);
        drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        wait_ready();
        drive_cycle(1'b0, 1'b1, 1'b0, 12'd2, '0);
        check("addr_wrap", sram_addr, 15);
        drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("adv_in_flight", sram_addr, 15);
        wait_ready();

        // rd+wr together at wp=2: read only, SRAM untouched.
        drive_cycle(1'b0, 1'b1, 1'b1, 12'd0, 16'hBEEF);
        check("collide_addr", sram_addr, 2);
        idle_cycles(5);
        check("collide_mem", sram_mem[2], 16'h0000);

        // rd while busy is ignored.
        wait_ready();
        rf_cnt = 0;
        drive_cycle(1'b0, 1'b1, 1'b0, 12'd1, '0);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'(i < 3), 1'b0, 12'd1, '0);
            if (read_finish) rf_cnt++;
        end
        check("single_read_finish", rf_cnt, 1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++)
            drive_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                        1'($urandom_range(0, 5) == 0), 12'($urandom), 16'($urandom));

        // Reset during WR_PULSE.
        wait_ready();
        drive_cycle(1'b0, 1'b0, 1'b1, 12'd0, 16'hA5A5);
        drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
        check("mid_we_low", sram_we_n, 1'b0);
        cmp_en = 1'b0;
        rst = 1'b0;
        #1;
        check("async_we_n", sram_we_n, 1'b1);
        check("async_dq_oe", sram_dq_oe, 1'b0);
        check("async_ce_n", sram_ce_n, 1'b1);
        check("async_no_wf", write_finish, 1'b0);
        reset_and_clear();
        idle_cycles(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/delay_ram_ctrl.md
# delay_ram_ctrl

Controller between the effect blocks' smart_ram request interface and the board's 16-bit asynchronous SRAM. It keeps a circular delay line by turning each relative `offset` into an absolute SRAM address (write pointer minus offset), runs the SRAM read/write cycle with programmable wait states, and returns one-cycle `read_finish` / `write_finish` pulses. After reset it zero-fills the whole delay memory so that delay effects never replay stale data.

## Interface
- `DATA_WIDTH`, 16, sample and SRAM data width
- `ADDR_WIDTH`, 12, width of the requested relative offset
- `SRAM_ADDR_WIDTH`, 18, physical SRAM address width, which is also the circular buffer depth (2^SRAM_ADDR_WIDTH words)
- `WAIT_CYCLES`, 2, SRAM access cycles per read, and `we_n` low-time per write (minimum 1)
- `CLEAR_ON_RESET`, 1, when 1, zero-fill the SRAM after reset

- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `advance`  in  1  one-cycle strobe at each new audio sample; increments the write pointer
- `rd`  in  1  read request (one-cycle pulse)
- `wr`  in  1  write request (one-cycle pulse)
- `offset`  in  ADDR_WIDTH  distance behind the write pointer
- `data_in`  in  DATA_WIDTH  write data
- `data_out`  out  DATA_WIDTH  read data; held until the next read completes
- `read_finish`  out  1  one-cycle pulse; `data_out` is valid
- `write_finish`  out  1  one-cycle pulse; the write has completed
- `ready`  out  1  high in IDLE; requests are accepted only when `ready` is high
- `sram_addr`  out  SRAM_ADDR_WIDTH  physical address
- `sram_dq_in`  in  DATA_WIDTH  SRAM data bus, read side
- `sram_dq_out`  out  DATA_WIDTH  SRAM data bus, drive side
- `sram_dq_oe`  out  1  enables the top-level tristate driver
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low

## Operation
- Write pointer `wp` is SRAM_ADDR_WIDTH bits wide. It resets to 0 and increments modulo 2^SRAM_ADDR_WIDTH on each `advance` pulse, in every state.
- Physical address = (`wp` − zero-extended `offset`) mod 2^SRAM_ADDR_WIDTH. The address is latched when the request is accepted; a later `advance` does not move an access already in flight.
- When `advance` and a request occur in the same cycle, the request uses the pre-increment `wp`.
- The state machine has these states: INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE, RD_ACCESS, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE.
  - **Reset:** enter INIT_SETUP if CLEAR_ON_RESET=1, otherwise IDLE.
  - **INIT:** write 0 to addresses 0 through 2^SRAM_ADDR_WIDTH−1, using the same setup / pulse / hold sequence as a normal write. After the last address, go to IDLE. `ready`=0 throughout, and `rd`/`wr` are ignored.
  - **IDLE + `rd`:** go to RD_ACCESS.
  - **IDLE + `wr` (without `rd`):** go to WR_SETUP, and latch `data_in`.
  - **IDLE + `rd` and `wr` together:** the read wins and the write is dropped (this is an illegal request; no flag is raised).
  - **RD_ACCESS:** lasts WAIT_CYCLES cycles; on its last cycle `sram_dq_in` is captured into `data_out`. Then RD_DONE for one cycle (`read_finish`=1), then IDLE.
  - **WR_SETUP:** one cycle. Then WR_PULSE for WAIT_CYCLES cycles with `sram_we_n`=0. Then WR_DONE for one cycle with `sram_we_n`=1, data still driven, and `write_finish`=1. Then IDLE.
- Requests arriving while `ready`=0 are ignored, not queued.
- Strobes by state:
  - `sram_ce_n`=0 in every state except IDLE.
  - `sram_oe_n`=0 only in RD_ACCESS.
  - `sram_dq_oe`=1 in the WR_* and INIT_* states.
  - `sram_addr` and `sram_dq_out` are registered and stable for the whole access.
- No arithmetic is performed on the data; it passes through bit-exact.

## Timing
- Reset values:
  - state as given under Reset above; `wp`=0; `data_out`=0.
  - `read_finish`=0, `write_finish`=0.
  - `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
  - `ready`=0 if CLEAR_ON_RESET=1, else 1.
- Read latency: `rd` accepted at cycle T; `read_finish`=1 at T+WAIT_CYCLES+1; `ready`=1 again at T+WAIT_CYCLES+2.
- Write latency: `wr` accepted at T; `write_finish`=1 at T+WAIT_CYCLES+2; `ready`=1 at T+WAIT_CYCLES+3.
- Each INIT word takes WAIT_CYCLES+2 cycles, so the full clear takes 2^SRAM_ADDR_WIDTH·(WAIT_CYCLES+2) cycles.
- Reset asserted mid-access: all strobes go inactive immediately (asynchronously), no finish pulse is issued, and the INIT sequence restarts.
- `wp` wrap-around: 2^SRAM_ADDR_WIDTH−1 → 0. The address subtraction wraps in the same way (for example `wp`=1, `offset`=2 gives address 2^SRAM_ADDR_WIDTH−1).

## Test plan
Use SRAM_ADDR_WIDTH=4, WAIT_CYCLES=2, and an SRAM behavioural model.
- **Post-reset clear:** release `rst` with the model pre-filled with 0xFFFF → `ready` rises after 16·4=64 cycles; all 16 words read back as 0x0000.
- **Write then read:** `wr` with `offset`=0, `data_in`=0x1234, `wp`=5 → `write_finish` at T+4, model address 5 holds 0x1234. Then `advance` ×3 and `rd` with `offset`=3 → address 5, `read_finish` at T+3, `data_out`=0x1234.
- **Wrap:** `wp`=1, `rd` with `offset`=2 → `sram_addr`=15. Pointer at 15 followed by `advance` → `wp`=0.
- **Collisions:**
  - `rd` and `wr` in the same cycle → only the read occurs and the model is unchanged.
  - `rd` while busy → ignored, and exactly one `read_finish` is seen.
  - `advance` during RD_ACCESS → `sram_addr` unchanged.
- **Reset mid-write:** assert `rst` during WR_PULSE → `sram_we_n`=1 and `sram_dq_oe`=0 within the same cycle; no `write_finish`; INIT restarts.
